// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg: shared mode encodings for the scan decoder and its benches
package scan_decoder_pkg;
  typedef enum logic {MODE_DIRECT = 1'b0, MODE_SCAN = 1'b1} mode_e;
endpackage

// File: rtl/scan_decoder_decoder_n.sv
// decoder_n: combinational N-to-2^N one-hot decode with enable
module decoder_n #(
  parameter int N = 2
) (
  input  logic            en,
  input  logic [N-1:0]    sel,
  output logic [(1<<N)-1:0] y
);
  localparam int M = 1 << N;
  assign y = en ? M'(1) << sel : '0;
endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot decoder with direct select or prescaled scanning index
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int N          = 2,
  parameter int PRESCALE   = 4,
  parameter bit ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              E,
  input  logic              mode,
  input  logic [N-1:0]      A,
  output logic [(1<<N)-1:0] D,
  output logic [N-1:0]      idx,
  output logic              wrap
);
  localparam int M  = 1 << N;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  logic [PW-1:0] pre, pre_n;
  logic [N-1:0]  idx_n, sel;
  logic [M-1:0]  y, d_q;
  logic          mode_q, clr, step;
  // a mode change restarts the scan from index 0 with an empty prescaler
  always_comb begin
    clr   = mode != MODE_SCAN || mode != mode_q;
    step  = !clr && E && pre == PMAX;
    pre_n = clr || step ? '0 : E ? pre + 1'b1 : pre;
    idx_n = clr ? '0 : step ? idx + 1'b1 : idx;
    sel   = mode == MODE_SCAN ? idx_n : A;
  end
  decoder_n #(.N(N)) u_dec (.en(E), .sel(sel), .y(y));
  always_ff @(posedge clk) begin
    if (rst) begin
      pre    <= '0;
      idx    <= '0;
      d_q    <= '0;
      wrap   <= 1'b0;
      mode_q <= mode;
    end else begin
      pre    <= pre_n;
      idx    <= idx_n;
      d_q    <= y;
      wrap   <= step && &idx;
      mode_q <= mode;
    end
  end
  assign D = ACTIVE_LOW ? ~d_q : d_q;
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: directed plus random stimulus against an enabled-cycle-count reference model
module tb_scan_decoder;
  logic clk = 0, rst = 1, E = 0, mode = 0;
  logic [1:0] A = 0;
  logic [2:0] A2 = 0;
  logic [3:0] D1;
  logic [7:0] D2;
  logic [1:0] idx1;
  logic [2:0] idx2;
  logic wrap1, wrap2;
  int errs = 0, checks = 0;
  int k[2];
  int pp[2] = '{4, 1};
  int mm[2] = '{4, 8};
  logic [7:0] ed[2];
  logic ew[2];
  logic pm;

  scan_decoder #(.N(2), .PRESCALE(4), .ACTIVE_LOW(0)) dut1 (
    .clk(clk), .rst(rst), .E(E), .mode(mode), .A(A), .D(D1), .idx(idx1), .wrap(wrap1));
  scan_decoder #(.N(3), .PRESCALE(1), .ACTIVE_LOW(1)) dut2 (
    .clk(clk), .rst(rst), .E(E), .mode(mode), .A(A2), .D(D2), .idx(idx2), .wrap(wrap2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // the index is the number of enabled scan cycles since the last clear, divided down by PRESCALE
  task automatic tick();
    logic [7:0] a;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      a = i ? 8'(A2) : 8'(A);
      if (rst) begin
        k[i] = 0; ed[i] = 0; ew[i] = 0;
      end else if (mode != pm || !mode) begin
        k[i] = 0; ew[i] = 0;
        ed[i] = E ? 8'(1) << (mode ? 8'd0 : a) : 8'd0;
      end else begin
        if (E) k[i]++;
        ew[i] = E && (k[i] % (pp[i] * mm[i]) == 0);
        ed[i] = E ? 8'(1) << ((k[i] / pp[i]) % mm[i]) : 8'd0;
      end
    end
    pm = mode;
    #1;
    chk("d1", 8'(D1), ed[0]);
    chk("idx1", 8'(idx1), 8'((k[0] / pp[0]) % mm[0]));
    chk("wrap1", 8'(wrap1), 8'(ew[0]));
    chk("d2", D2, ~ed[1]);
    chk("idx2", 8'(idx2), 8'((k[1] / pp[1]) % mm[1]));
    chk("wrap2", 8'(wrap2), 8'(ew[1]));
    chk("onehot", 8'($onehot0(D1) && $onehot0(~D2)), 8'd1);
  endtask

  initial begin
    pm = 0;
    tick();
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin A = 2'(i); A2 = 3'(i); tick(); end
    E = 1;
    for (int i = 0; i < 4; i++) begin A = 2'(i); A2 = 3'(7 - i); tick(); end
    mode = 1;
    for (int i = 0; i < 20; i++) tick();
    for (int i = 0; i < 40 && k[0] % 16 != 9; i++) tick();
    E = 0;
    for (int i = 0; i < 6; i++) tick();
    E = 1;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 40 && (k[0] / 4) % 4 != 3; i++) tick();
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 6; i++) tick();
    mode = 0; A = 2'd3; A2 = 3'd7;
    tick(); tick();
    mode = 1;
    tick(); tick();
    mode = 0;
    tick(); tick();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(19) == 0) mode = ~mode;
      E = $urandom_range(3) != 0;
      A = 2'($urandom);
      A2 = 3'($urandom);
      rst = $urandom_range(49) == 0;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter N, default 2, select width; the block SHALL decode N bits to 2^N outputs, N range 1..5.
REQ-002 Parameter PRESCALE, default 4, clock cycles per scan step in scan mode; the block SHALL support the range 1..65535.
REQ-003 Parameter ACTIVE_LOW, default 0; when 1, D SHALL be the bitwise inverse of the active-high value.
REQ-004 clk  input  1  rising-edge clock; single clock domain for the block.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 E  input  1  enable; 0 forces all outputs inactive.
REQ-007 mode  input  1  operating mode: 0 = direct, 1 = scan.
REQ-008 A  input  N  select input, used in direct mode only.
REQ-009 D  output  2^N  registered one-hot decode output.
REQ-010 idx  output  N  current scan index; holds 0 in direct mode.
REQ-011 wrap  output  1  one-cycle pulse when the scan index rolls over from 2^N-1 to 0.

Function
REQ-012 Direct mode: D SHALL be onehot(A) one clock after sampling when E=1, and all-inactive one clock after sampling when E=0; latency is exactly 1 cycle.
REQ-013 Scan mode: a prescaler counting 0..PRESCALE-1 SHALL advance only while E=1, and idx SHALL increment modulo 2^N on the cycle the prescaler is at PRESCALE-1 and then return the prescaler to 0.
REQ-014 Scan mode: D SHALL equal onehot(idx) registered, so D is one-hot on idx whenever E=1 and all-inactive whenever E=0.
REQ-015 When E=0 in scan mode, idx and the prescaler SHALL hold their values, and scanning SHALL resume from the held state when E returns to 1.
REQ-016 wrap SHALL be 1 for exactly the one cycle after idx changes from 2^N-1 to 0, and 0 otherwise, including in direct mode and when E=0.
REQ-017 PRESCALE=1: idx SHALL advance every enabled cycle.
REQ-018 N=1: idx SHALL toggle 0/1 and wrap SHALL assert on every second step.
REQ-019 A change of mode sampled on any cycle SHALL clear idx and the prescaler to 0 on the next edge; the first scan output after entering scan mode SHALL be onehot(0).
REQ-020 D SHALL never have more than one active bit in any cycle.
REQ-021 All arithmetic SHALL be unsigned; the prescaler SHALL be sized to hold PRESCALE-1.

Reset
REQ-022 When rst=1 at a clock edge, D SHALL go all-inactive (0, or all-ones if ACTIVE_LOW=1), idx SHALL go to 0, the prescaler SHALL go to 0, and wrap SHALL go to 0.
REQ-023 rst SHALL take priority over E and mode; a reset asserted mid-scan SHALL abandon the scan, and the first step after reset release SHALL be at idx=0 after a full PRESCALE period.

Structure
REQ-024 Mode encodings (MODE_DIRECT=0, MODE_SCAN=1) SHALL live in a shared constants header/package used by RTL and benches.
REQ-025 The combinational N-to-2^N decode SHALL be a sub-module named decoder_n (inputs en and sel, output y).
REQ-026 The prescaler, index counter, mode-change detect and output register SHALL live in scan_decoder itself.

Verification (N=2, PRESCALE=4, ACTIVE_LOW=0 unless stated)
REQ-027 Direct mode, E=0, A=00..11 each held 5 ns -> D=0000 throughout; then E=1, A=00,01,10,11 -> D=0001,0010,0100,1000, each one cycle after A is sampled.
REQ-028 Scan mode, E=1 held for 20 cycles -> idx steps 0,1,2,3,0 every 4 cycles, D follows onehot(idx), and wrap pulses once at the 3->0 rollover.
REQ-029 Scan mode, E dropped for 6 cycles at idx=2 with the prescaler at 1 -> D=0000 and idx stays 2; after E returns, idx reaches 3 exactly 3 enabled cycles later.
REQ-030 rst asserted for 1 cycle at idx=3 -> the next cycle shows D=0000, idx=0, wrap=0; after release, the first step occurs after 4 cycles.
REQ-031 Toggle mode from direct to scan while A=11 -> D=0001 and idx=0 on the next edge; back to direct -> D=onehot(A) one cycle later and idx=0.
REQ-032 Parameter sweep with N=3, PRESCALE=1, ACTIVE_LOW=1 -> D walks a single 0 through 8 bits every cycle, and wrap pulses every 8 cycles.
